// File: rtl/sub_seq_pkg.sv
// Shared definitions for the multi-precision subtract sequencer.
//   WORD_W    : width of one datapath word
//   state_e   : sequencer FSM states
//   idx_width : width of the word index for a given word count (minimum 1)
package sub_seq_pkg;

   localparam int unsigned WORD_W = 32;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_DONE = 2'd2
   } state_e;

   function automatic int unsigned idx_width(input int unsigned words);
      return (words <= 1) ? 1 : $clog2(words);
   endfunction

endpackage

// File: rtl/sub_full_32.sv
// 32-bit full subtractor: d_o = a_i - b_i - bin_i (mod 2^32), bout_o = borrow out.
//   a_i, b_i : operands
//   bin_i    : borrow in
//   d_o      : difference
//   bout_o   : borrow out (1 when a_i < b_i + bin_i)
module sub_full_32
   import sub_seq_pkg::*;
(
   input  logic [WORD_W-1:0] a_i,
   input  logic [WORD_W-1:0] b_i,
   input  logic              bin_i,
   output logic [WORD_W-1:0] d_o,
   output logic              bout_o
);

   logic [WORD_W:0] diff;

   // One extra bit on the left captures the borrow as the sign of the wide result.
   assign diff   = {1'b0, a_i} - {1'b0, b_i} - {{WORD_W{1'b0}}, bin_i};
   assign d_o    = diff[WORD_W-1:0];
   assign bout_o = diff[WORD_W];

endmodule

// File: rtl/sub_seq_ctrl.sv
// Multi-precision subtract sequencer: computes d = a - b - bin over WORDS 32-bit words by
// driving one shared sub_full_32 one word per cycle, least-significant word first.
//   clk, reset          : clock, asynchronous active-high reset
//   in_valid / in_ready : request handshake carrying a, b, bin
//   out_valid/out_ready : result handshake carrying d, bout, zero
//   busy                : request accepted and not yet retired
module sub_seq_ctrl
   import sub_seq_pkg::*;
#(
   parameter int unsigned WORDS = 4
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  in_valid,
   output logic                  in_ready,
   input  logic [WORD_W*WORDS-1:0] a,
   input  logic [WORD_W*WORDS-1:0] b,
   input  logic                  bin,
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic [WORD_W*WORDS-1:0] d,
   output logic                  bout,
   output logic                  zero,
   output logic                  busy
);

   localparam int unsigned IdxW = idx_width(WORDS);

   state_e                         state_q;
   logic [IdxW-1:0]                idx_q;
   logic                           borrow_q;
   logic [WORDS-1:0][WORD_W-1:0]   a_q;
   logic [WORDS-1:0][WORD_W-1:0]   b_q;
   logic [WORDS-1:0][WORD_W-1:0]   d_q;
   logic                           bout_q;
   logic                           zero_q;

   logic [WORD_W-1:0]              sub_d;
   logic                           sub_bout;

   // Word mux in front of the single shared subtractor.
   sub_full_32 u_sub (
      .a_i    (a_q[idx_q]),
      .b_i    (b_q[idx_q]),
      .bin_i  (borrow_q),
      .d_o    (sub_d),
      .bout_o (sub_bout)
   );

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q  <= ST_IDLE;
         idx_q    <= '0;
         borrow_q <= 1'b0;
         a_q      <= '0;
         b_q      <= '0;
         d_q      <= '0;
         bout_q   <= 1'b0;
         zero_q   <= 1'b0;
      end else begin
         unique case (state_q)
            ST_IDLE: begin
               if (in_valid) begin
                  a_q      <= a;
                  b_q      <= b;
                  borrow_q <= bin;
                  idx_q    <= '0;
                  zero_q   <= 1'b1;
                  state_q  <= ST_RUN;
               end
            end
            ST_RUN: begin
               d_q[idx_q] <= sub_d;
               borrow_q   <= sub_bout;
               zero_q     <= zero_q & (sub_d == '0);
               if (idx_q == IdxW'(WORDS - 1)) begin
                  // Only the top word's borrow is exposed.
                  bout_q  <= sub_bout;
                  state_q <= ST_DONE;
               end else begin
                  idx_q <= idx_q + 1'b1;
               end
            end
            ST_DONE: begin
               if (out_ready) begin
                  state_q <= ST_IDLE;
               end
            end
            default: state_q <= ST_IDLE;
         endcase
      end
   end

   assign in_ready  = (state_q == ST_IDLE);
   assign out_valid = (state_q == ST_DONE);
   assign busy      = (state_q != ST_IDLE);
   assign d         = d_q;
   assign bout      = bout_q;
   assign zero      = zero_q;

endmodule

// File: tb/tb_sub_seq_ctrl.sv
// Self-checking bench for sub_seq_ctrl (WORDS=4): directed cases plus randomized requests
// against an arithmetic reference model of the wide subtraction.
module tb_sub_seq_ctrl;

   localparam int unsigned WORDS = 4;
   localparam int unsigned W     = 32 * WORDS;

   logic          clk = 1'b0;
   logic          reset;
   logic          in_valid;
   logic          in_ready;
   logic [W-1:0]  a;
   logic [W-1:0]  b;
   logic          bin;
   logic          out_valid;
   logic          out_ready;
   logic [W-1:0]  d;
   logic          bout;
   logic          zero;
   logic          busy;

   int checks = 0;
   int errors = 0;

   sub_seq_ctrl #(.WORDS(WORDS)) dut (
      .clk       (clk),
      .reset     (reset),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .a         (a),
      .b         (b),
      .bin       (bin),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .d         (d),
      .bout      (bout),
      .zero      (zero),
      .busy      (busy)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [W:0] obs, input logic [W:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   function automatic logic [W-1:0] rand_wide();
      logic [W-1:0] v;
      for (int i = 0; i < WORDS; i++) v[32*i +: 32] = $urandom;
      return v;
   endfunction

   task automatic check_reset_values(input string tag);
      chk({tag, "_d"}, {1'b0, d}, '0);
      chk({tag, "_bout"}, {{W{1'b0}}, bout}, '0);
      chk({tag, "_zero"}, {{W{1'b0}}, zero}, '0);
      chk({tag, "_out_valid"}, {{W{1'b0}}, out_valid}, '0);
      chk({tag, "_busy"}, {{W{1'b0}}, busy}, '0);
      chk({tag, "_in_ready"}, {{W{1'b0}}, in_ready}, 1);
   endtask

   // Issue one request, check latency and result, stall `stall` cycles, then retire it.
   // With pulse set, a second in_valid is driven during the stall and must be ignored.
   task automatic run_req(input logic [W-1:0] av, input logic [W-1:0] bv, input logic bi,
                          input int stall, input bit pulse);
      logic [W:0]   diff;
      logic [W-1:0] exp_d;
      logic         exp_bout;
      logic         exp_zero;
      diff     = {1'b0, av} - {1'b0, bv} - {{W{1'b0}}, bi};
      exp_d    = diff[W-1:0];
      exp_bout = diff[W];
      exp_zero = (exp_d == '0);

      chk("ready_before_req", {{W{1'b0}}, in_ready}, 1);
      a = av; b = bv; bin = bi; in_valid = 1'b1;
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      // Scramble inputs so the result must come from latched operands.
      a = rand_wide(); b = rand_wide(); bin = $urandom_range(0, 1);
      for (int k = 1; k < WORDS; k++) begin
         @(posedge clk);
         #1;
         chk("run_out_valid", {{W{1'b0}}, out_valid}, 0);
         chk("run_busy", {{W{1'b0}}, busy}, 1);
         chk("run_in_ready", {{W{1'b0}}, in_ready}, 0);
      end
      @(posedge clk);
      #1;
      chk("done_out_valid", {{W{1'b0}}, out_valid}, 1);
      chk("done_d", {1'b0, d}, {1'b0, exp_d});
      chk("done_bout", {{W{1'b0}}, bout}, {{W{1'b0}}, exp_bout});
      chk("done_zero", {{W{1'b0}}, zero}, {{W{1'b0}}, exp_zero});
      for (int k = 0; k < stall; k++) begin
         if (pulse && k == 4) begin
            a = rand_wide(); b = rand_wide(); in_valid = 1'b1;
         end else begin
            in_valid = 1'b0;
         end
         @(posedge clk);
         #1;
         chk("stall_out_valid", {{W{1'b0}}, out_valid}, 1);
         chk("stall_in_ready", {{W{1'b0}}, in_ready}, 0);
         chk("stall_d", {1'b0, d}, {1'b0, exp_d});
         chk("stall_bout", {{W{1'b0}}, bout}, {{W{1'b0}}, exp_bout});
      end
      in_valid  = 1'b0;
      out_ready = 1'b1;
      @(posedge clk);
      #1;
      out_ready = 1'b0;
      chk("retire_out_valid", {{W{1'b0}}, out_valid}, 0);
      chk("retire_in_ready", {{W{1'b0}}, in_ready}, 1);
      chk("retire_busy", {{W{1'b0}}, busy}, 0);
      chk("retire_d_hold", {1'b0, d}, {1'b0, exp_d});
      chk("retire_bout_hold", {{W{1'b0}}, bout}, {{W{1'b0}}, exp_bout});
      if (pulse) begin
         // The ignored pulse must not have started a request.
         @(posedge clk);
         #1;
         chk("pulse_not_accepted", {{W{1'b0}}, busy}, 0);
      end
   endtask

   initial begin
      logic [W-1:0] av;
      logic [W-1:0] bv;
      reset = 1'b1; in_valid = 1'b1; out_ready = 1'b0;
      a = '0; b = '0; bin = 1'b0;
      #2;
      check_reset_values("reset0");
      @(posedge clk);
      #1;
      check_reset_values("reset_inval_ignored");
      in_valid = 1'b0;
      #2 reset = 1'b0;
      @(posedge clk);
      #1;

      // out_ready in IDLE has no effect.
      out_ready = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      out_ready = 1'b0;
      chk("idle_out_ready_valid", {{W{1'b0}}, out_valid}, 0);
      chk("idle_out_ready_ready", {{W{1'b0}}, in_ready}, 1);

      run_req(W'(100), W'(99), 1'b0, 0, 1'b0);
      run_req(W'(29), W'(38), 1'b0, 0, 1'b0);
      run_req(W'(1) << 96, W'(1), 1'b0, 0, 1'b0);
      run_req(W'(120097), W'(120095), 1'b1, 0, 1'b0);
      av = 128'hDEAD_BEEF_0123_4567_89AB_CDEF_0F0F_F0F0;
      run_req(av, av, 1'b0, 0, 1'b0);
      run_req('0, '0, 1'b1, 0, 1'b0);
      run_req(W'(97201), W'(100095), 1'b0, 10, 1'b1);

      // Reset mid-RUN, asserted off-edge two cycles after accept.
      a = W'(12345); b = W'(7); bin = 1'b0; in_valid = 1'b1;
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      repeat (2) @(posedge clk);
      #2 reset = 1'b1;
      #1;
      check_reset_values("reset_mid_run");
      in_valid = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      check_reset_values("reset_held");
      in_valid = 1'b0;
      #2 reset = 1'b0;
      run_req(W'(5), W'(3), 1'b0, 0, 1'b0);

      // Randomized requests with occasional equal operands and random stalls.
      for (int n = 0; n < 24; n++) begin
         av = rand_wide();
         bv = ($urandom_range(0, 4) == 0) ? av : rand_wide();
         if ($urandom_range(0, 3) == 0) bv[W-1:32] = av[W-1:32];
         run_req(av, bv, 1'($urandom_range(0, 1)), $urandom_range(0, 3), 1'b0);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   // Global watchdog so the bench always terminates.
   initial begin
      #200000;
      $display("FAIL watchdog timeout");
      $fatal(1, "timeout");
   end

endmodule
